// File: rtl/hline_pkg.sv
// Shared definitions for the horizontal-line motion controller and its Y counter.
//   state_e        : controller state encoding (2-bit)
//   DirInc/DirDec  : direction encodings carried on the dir output
//   YMin/YMax      : counter terminal counts that drive bot_hit/top_hit
package hline_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StStep = 2'd2,
    StLoad = 2'd3
  } state_e;

  localparam logic DirInc = 1'b1;
  localparam logic DirDec = 1'b0;

  localparam int unsigned YMin = 18;
  localparam int unsigned YMax = 630;

  // Limit flag relevant to the direction of travel.
  function automatic logic limit_ahead(input logic dir, input logic top_hit,
                                       input logic bot_hit);
    return (dir == DirInc) ? top_hit : bot_hit;
  endfunction

endpackage

// File: rtl/hline_frame_div.sv
// Frame divider: counts frame ticks and pulses move_tick_o on the tick that
// completes a group of FrameDiv ticks.
//   clk_i       : system clock
//   rst_ni      : synchronous active-low reset
//   clear_i     : synchronous clear of the tick count (wins over tick_i)
//   tick_i      : one-cycle frame pulse, already qualified by the controller
//   move_tick_o : combinational pulse, high with the qualifying tick_i
module hline_frame_div #(
  parameter int unsigned FrameDiv = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic tick_i,
  output logic move_tick_o
);

  logic [7:0] cnt_q, cnt_d;

  assign move_tick_o = tick_i & ~clear_i & (cnt_q == 8'(FrameDiv - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || move_tick_o) begin
      cnt_d = 8'd0;
    end else if (tick_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hline_motion_ctrl.sv
// Motion controller for the horizontal-line Y counter. Every FRAME_DIV frames
// it issues a burst of STEP count enables in the current direction, reverses
// on the terminal-count flag for that direction, and sequences a one-cycle
// parallel load of the switch value.
//   clk        : system clock
//   reset      : synchronous active-low reset
//   frame_tick : one-cycle pulse per video frame
//   run_en     : level, motion enabled
//   load_req   : one-cycle pulse, load the switch value into the counter
//   top_hit    : counter at YMax
//   bot_hit    : counter at YMin
//   UP/DW/LD   : counter increment / decrement / load enables
//   dir        : current direction (1 = increment)
//   busy       : burst or load in progress
module hline_motion_ctrl #(
  parameter int unsigned STEP      = 2,
  parameter int unsigned FRAME_DIV = 1,
  parameter bit          DIR_INIT  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic run_en,
  input  logic load_req,
  input  logic top_hit,
  input  logic bot_hit,
  output logic UP,
  output logic DW,
  output logic LD,
  output logic dir,
  output logic busy
);

  import hline_pkg::*;

  state_e     state_q, state_d;
  logic [3:0] step_cnt_q, step_cnt_d;
  logic       dir_q, dir_d;
  logic       up, dw;
  logic       fd_clear, move_tick;
  logic       hit_cur, step_en;

  // Ticks only count while armed and undisturbed; a tick coinciding with
  // load_req or a run_en drop is discarded.
  assign fd_clear = (state_q != StWait) | load_req | ~run_en;

  hline_frame_div #(
    .FrameDiv(FRAME_DIV)
  ) u_frame_div (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clear_i    (fd_clear),
    .tick_i     (frame_tick),
    .move_tick_o(move_tick)
  );

  // Mealy enables: the limit flag suppresses the enable in the very cycle the
  // counter reaches the terminal count, so Y never overshoots.
  assign hit_cur = limit_ahead(dir_q, top_hit, bot_hit);
  assign step_en = run_en & ~hit_cur;

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    dir_d      = dir_q;
    up         = 1'b0;
    dw         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_req) begin
          state_d = StLoad;
        end else if (run_en) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (load_req) begin
          state_d = StLoad;
        end else if (!run_en) begin
          state_d = StIdle;
        end else if (move_tick) begin
          state_d    = StStep;
          step_cnt_d = 4'd0;
        end
      end
      StStep: begin
        up = step_en & (dir_q == DirInc);
        dw = step_en & (dir_q == DirDec);
        step_cnt_d = step_cnt_q + 4'd1;
        if (load_req) begin
          state_d = StLoad;
        end else if (!run_en) begin
          state_d = StIdle;
        end else if (top_hit && bot_hit) begin
          // Both limits at once is illegal: stop quietly, keep direction.
          state_d = StWait;
        end else if (hit_cur) begin
          dir_d   = ~dir_q;
          state_d = StWait;
        end else if (step_cnt_q == 4'(STEP - 1)) begin
          state_d = StWait;
        end
      end
      StLoad: begin
        dir_d = DIR_INIT;
        if (load_req) begin
          state_d = StLoad;
        end else if (run_en) begin
          state_d = StWait;
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      step_cnt_q <= 4'd0;
      dir_q      <= DIR_INIT;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      dir_q      <= dir_d;
    end
  end

  // Outputs are held low for the whole time reset is asserted.
  assign UP   = reset & up;
  assign DW   = reset & dw;
  assign LD   = reset & (state_q == StLoad);
  assign busy = reset & ((state_q == StStep) | (state_q == StLoad));
  assign dir  = dir_q;

endmodule

// File: tb/tb_hline_motion_ctrl.sv
module tb_hline_motion_ctrl;

  import hline_pkg::*;

  localparam int unsigned Step     = 2;
  localparam int unsigned FrameDiv = 3;
  localparam bit          DirInit  = 1'b1;

  logic clk = 1'b0;
  logic reset, frame_tick, run_en, load_req, top_hit, bot_hit;
  logic up, dw, ld, dir, busy;
  int   sw;

  always #5 clk = ~clk;

  hline_motion_ctrl #(
    .STEP     (Step),
    .FRAME_DIV(FrameDiv),
    .DIR_INIT (DirInit)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .run_en    (run_en),
    .load_req  (load_req),
    .top_hit   (top_hit),
    .bot_hit   (bot_hit),
    .UP        (up),
    .DW        (dw),
    .LD        (ld),
    .dir       (dir),
    .busy      (busy)
  );

  typedef struct {
    logic [4:0] outs;  // {UP, DW, LD, dir, busy}
    int         y;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: a burst is "steps_left" enables still owed, "armed"
  // means motion is enabled and frames are being counted, "loading" means
  // the counter is being loaded this cycle.
  bit m_loading = 1'b0;
  bit m_armed   = 1'b0;
  bit m_dir     = DirInit;
  int m_frames  = 0;
  int m_left    = 0;
  int y_m       = 100;  // counter Y following the model's enables
  int y_d       = 100;  // counter Y following the DUT's enables

  task automatic cycle(input bit r, input bit ft, input bit re, input bit lr,
                       input bit ill, input int swv);
    bit th, bh, u, d, l, b, moving, hit;
    th = ill ? 1'b1 : (y_m == int'(YMax));
    bh = ill ? 1'b1 : (y_m == int'(YMin));
    reset = r; frame_tick = ft; run_en = re; load_req = lr;
    top_hit = th; bot_hit = bh; sw = swv;
    u = 0; d = 0; l = 0; b = 0;
    if (r) begin
      l      = m_loading;
      b      = m_loading || (m_left > 0);
      moving = (m_left > 0) && !m_loading && re;
      hit    = m_dir ? th : bh;
      u      = moving && m_dir && !hit;
      d      = moving && !m_dir && !hit;
    end
    sb_q.push_back('{outs: {u, d, l, m_dir, b}, y: y_m});
    @(posedge clk);
    if (l) y_m = swv;
    else if (u) y_m = y_m + 1;
    else if (d) y_m = y_m - 1;
    if (!r) begin
      m_loading = 0; m_left = 0; m_armed = 0; m_frames = 0; m_dir = DirInit;
    end else if (lr) begin
      if (m_loading) m_dir = DirInit;
      m_loading = 1; m_left = 0; m_frames = 0;
    end else if (m_loading) begin
      m_loading = 0; m_dir = DirInit; m_armed = re; m_frames = 0;
    end else if (m_left > 0) begin
      if (!re) begin
        m_left = 0; m_armed = 0;
      end else if (th && bh) begin
        m_left = 0;
      end else if (m_dir ? th : bh) begin
        m_dir = !m_dir; m_left = 0;
      end else begin
        m_left = m_left - 1;
      end
    end else if (!m_armed) begin
      if (re) begin
        m_armed = 1; m_frames = 0;
      end
    end else if (!re) begin
      m_armed = 0;
    end else if (ft) begin
      m_frames = m_frames + 1;
      if (m_frames == int'(FrameDiv)) begin
        m_frames = 0; m_left = Step;
      end
    end
    #1;
  endtask

  // One run_en-high frame: a tick followed by quiet cycles.
  task automatic frame(input int gap);
    cycle(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < gap; i++) cycle(1, 0, 1, 0, 0, 0);
  endtask

  // Monitor: compare the DUT against the queued expectation every cycle.
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({up, dw, ld, dir, busy} !== e.outs) begin
          n_fail++;
          $display("FAIL outputs t=%0t {UP,DW,LD,dir,busy} got %b expected %b",
                   $time, {up, dw, ld, dir, busy}, e.outs);
        end
        n_cmp++;
        if (y_d != e.y) begin
          n_fail++;
          $display("FAIL ycount t=%0t got %0d expected %0d", $time, y_d, e.y);
        end
        if (ld === 1'b1) y_d = sw;
        else if (up === 1'b1) y_d = y_d + 1;
        else if (dw === 1'b1) y_d = y_d - 1;
      end
    end
  end

  initial begin
    int pick, swv;
    reset = 0; frame_tick = 0; run_en = 0; load_req = 0;
    top_hit = 0; bot_hit = 0; sw = 0;
    @(posedge clk);
    #1;
    // Reset held with inputs toggling.
    for (int i = 0; i < 3; i++) cycle(0, bit'(i % 2), bit'((i + 1) % 2), 0, 0, 0);
    // Load 100, then six frames: two bursts of two UPs.
    cycle(1, 0, 1, 1, 0, 100);
    for (int i = 0; i < 6; i++) frame(2);
    // Approach the top limit, reverse, then step down.
    cycle(1, 0, 1, 1, 0, 629);
    for (int i = 0; i < 6; i++) frame(2);
    // Load in the first cycle of a burst.
    frame(1); frame(1);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 1, 0, 300);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 0);
    // Load coincident with the qualifying tick: no burst that frame.
    frame(1); frame(1);
    cycle(1, 1, 1, 1, 0, 400);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 0);
    // run_en falls in the first burst cycle.
    frame(1); frame(1);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    // Reset during a load.
    cycle(1, 0, 1, 1, 0, 200);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    // Free run with random disturbances and loads biased toward the limits.
    repeat (20000) begin
      pick = $urandom_range(0, 2);
      if (pick == 0) swv = $urandom_range(18, 22);
      else if (pick == 1) swv = $urandom_range(626, 630);
      else swv = $urandom_range(18, 630);
      cycle($urandom_range(0, 999) != 0, bit'($urandom_range(0, 1)),
            $urandom_range(0, 99) != 0, $urandom_range(0, 399) == 0,
            $urandom_range(0, 299) == 0, swv);
    end
    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hline_motion_ctrl.md
Name: hline_motion_ctrl

Overview:
- Motion controller directly upstream of the horizontal-line Y-coordinate counter; generates that counter's UP/DW/LD enables.
- Once per N frames it issues a burst of STEP single-cycle count enables in the current direction.
- Reverses direction when the counter reports a limit: top_hit at Y=630 (upper terminal count), bot_hit at Y=18 (lower terminal count).
- Also sequences a one-cycle load of the switch value into the counter.

Parameters:
- STEP, 2: count enables issued per move burst (1..15).
- FRAME_DIV, 1: frame ticks per move burst (1..255).
- DIR_INIT, 1: direction after reset or load (1 = increment Y, 0 = decrement Y).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; all state clears on a clk edge while reset=0.
- frame_tick  in  1  one-cycle pulse per video frame.
- run_en  in  1  level; 1 = motion enabled.
- load_req  in  1  one-cycle pulse; load the switch value into the counter.
- top_hit  in  1  counter Y == 630.
- bot_hit  in  1  counter Y == 18.
- UP  out  1  counter increment enable.
- DW  out  1  counter decrement enable.
- LD  out  1  counter parallel-load enable.
- dir  out  1  current direction (1 = increment).
- busy  out  1  high while in S_STEP or S_LOAD.

Behaviour:
- States:
  - S_IDLE: no motion.
  - S_WAIT: armed, counting frames.
  - S_STEP: issuing the burst.
  - S_LOAD: one-cycle load.
- Reset (reset=0 at an edge): state=S_IDLE, frame_cnt=0, step_cnt=0, dir=DIR_INIT, LD=0. UP, DW and busy are 0 throughout reset.
- S_IDLE:
  - load_req -> S_LOAD.
  - Else run_en=1 -> S_WAIT with frame_cnt=0.
- S_WAIT:
  - Each frame_tick increments frame_cnt.
  - When frame_cnt reaches FRAME_DIV-1 and frame_tick=1 -> S_STEP, step_cnt=0, frame_cnt=0.
  - run_en=0 -> S_IDLE.
- S_STEP:
  - UP and DW are combinational (Mealy) so a limit is seen the same cycle the counter reaches it; no overshoot.
  - UP = dir & ~top_hit.
  - DW = ~dir & ~bot_hit.
  - step_cnt increments every cycle.
  - If the flag for the current direction is 1: no enable this cycle, dir toggles, -> S_WAIT. The rest of the burst is discarded.
  - Else, after STEP enables -> S_WAIT.
  - Latency: first enable appears in the cycle after the qualifying frame_tick.
- S_LOAD:
  - LD=1 for exactly one cycle; dir <= DIR_INIT.
  - Next state is S_WAIT if run_en=1, else S_IDLE.
  - LD and UP/DW are never high in the same cycle.
- Priorities:
  - load_req outranks everything in any state. It enters S_LOAD next cycle and abandons any burst.
  - A frame_tick in the same cycle as load_req is dropped.
  - run_en=0 in S_STEP: UP/DW deassert in that same cycle, -> S_IDLE; dir is retained.
- Limit flags while not in S_STEP are ignored.
- top_hit and bot_hit both 1 (illegal): no enables, dir unchanged, -> S_WAIT.
- frame_cnt is 8-bit and wraps only through the explicit clear; step_cnt is 4-bit.
- frame_tick arriving during S_STEP is ignored (it does not count toward the next burst).

Decomposition:
- Shared package hline_pkg:
  - State encoding (2-bit, S_IDLE=0, S_WAIT=1, S_STEP=2, S_LOAD=3).
  - DIR_INC=1, DIR_DEC=0.
  - Y_MIN=18, Y_MAX=630 (also used to build the counter's terminal-count decodes).
- One sub-module: hline_frame_div. It holds the FRAME_DIV tick counter with sync clear and produces a move_tick pulse; the FSM stays in the top module.

Test Plan:
1. Reset held low 3 cycles with frame_tick/run_en toggling -> UP=DW=LD=busy=0, dir=1. Release, run_en=1, frame_tick -> UP high exactly 2 consecutive cycles starting the next cycle; counter model goes 100 -> 102.
2. FRAME_DIV=3, run_en=1, 6 frame_ticks -> exactly 2 bursts, issued after ticks 3 and 6; total 4 UP pulses, DW never high.
3. Counter model at Y=629, dir=1, burst -> one UP (Y=630). Next cycle top_hit=1 gives UP=0 and dir=0. Next burst issues 2 DW pulses; Y ends at 628.
4. Y=19, dir=0 -> one DW (Y=18), bot_hit stops the burst, dir=1. Y never goes below 18 or above 630 over 2000 frames of free run.
5. load_req in mid-burst -> UP drops next cycle; LD=1 for exactly 1 cycle; dir=DIR_INIT; state returns to S_WAIT. load_req coincident with frame_tick -> no burst that frame.
6. run_en falls in the first cycle of a burst -> zero enables that cycle, state S_IDLE. reset=0 asserted during S_LOAD -> LD=0 next cycle, state S_IDLE.
